// File: rtl/index_register_file.sv
// Index register file: NUM_REGS registers (X, Y, ...) with load, transfer,
// increment and decrement, two combinational read ports and N/Z flags.
module index_register_file #(
  parameter int          WIDTH       = 8,
  parameter int          NUM_REGS    = 2,
  parameter logic [31:0] RESET_VALUE = 32'h0,
  localparam int         SEL_W       = (NUM_REGS <= 2) ? 1 : $clog2(NUM_REGS)
) (
  input  logic             fclk,
  input  logic             resb,
  input  logic             load,
  input  logic [SEL_W-1:0] wr_sel,
  input  logic [WIDTH-1:0] db_in,
  input  logic             xfer,
  input  logic [SEL_W-1:0] xfer_src,
  input  logic             inc,
  input  logic             dec,
  input  logic [SEL_W-1:0] rd_sel,
  input  logic [SEL_W-1:0] addr_sel,
  output logic [WIDTH-1:0] db_out,
  output logic [WIDTH-1:0] address_out,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_upd,
  output logic             wrap
);

  localparam int               SLOTS = 2 ** SEL_W;
  localparam logic [WIDTH-1:0] RST_V = RESET_VALUE[WIDTH-1:0];

  logic [WIDTH-1:0] regs_q [NUM_REGS];
  logic [WIDTH-1:0] pad    [SLOTS];

  logic             flag_n_q;
  logic             flag_z_q;
  logic             upd_q;
  logic             wrap_q;

  logic             we_d;
  logic [WIDTH-1:0] wdata_d;
  logic             wrap_d;

  logic             do_load;
  logic             do_xfer;
  logic             do_inc;
  logic             do_dec;
  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] src;
  logic             wr_ok;
  logic             src_ok;

  function automatic logic sel_ok(input logic [SEL_W-1:0] s);
    return int'(s) < NUM_REGS;
  endfunction

  // Pad the register array to a power of two; spare slots read as zero.
  always_comb begin
    for (int i = 0; i < SLOTS; i++) begin
      pad[i] = '0;
    end
    for (int i = 0; i < NUM_REGS; i++) begin
      pad[i] = regs_q[i];
    end
  end

  // Read ports show pre-edge contents only.
  always_comb begin
    db_out      = pad[rd_sel];
    address_out = pad[addr_sel];
  end

  // One-hot operation select: load > xfer > inc > dec, inc+dec cancels.
  always_comb begin
    do_load = load;
    do_xfer = ~load & xfer;
    do_inc  = ~load & ~xfer & inc & ~dec;
    do_dec  = ~load & ~xfer & dec & ~inc;
  end

  // Write data, write enable and wrap detect for the selected operation.
  always_comb begin
    cur     = pad[wr_sel];
    src     = pad[xfer_src];
    wr_ok   = sel_ok(wr_sel);
    src_ok  = sel_ok(xfer_src);
    we_d    = 1'b0;
    wdata_d = cur;
    wrap_d  = 1'b0;
    unique case (1'b1)
      do_load: begin
        we_d    = wr_ok;
        wdata_d = db_in;
      end
      do_xfer: begin
        we_d    = wr_ok & src_ok;
        wdata_d = src;
      end
      do_inc: begin
        we_d    = wr_ok;
        wdata_d = cur + WIDTH'(1);
        wrap_d  = wr_ok & (&cur);
      end
      do_dec: begin
        we_d    = wr_ok;
        wdata_d = cur - WIDTH'(1);
        wrap_d  = wr_ok & ~(|cur);
      end
      default: begin
        we_d = 1'b0;
      end
    endcase
  end

  // Register array: one write per cycle, reset dominates.
  always_ff @(posedge fclk) begin
    if (!resb) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= RST_V;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (we_d && (wr_sel == SEL_W'(i))) begin
          regs_q[i] <= wdata_d;
        end
      end
    end
  end

  // Flags follow the last written value; pulses last one cycle.
  always_ff @(posedge fclk) begin
    if (!resb) begin
      flag_n_q <= RST_V[WIDTH-1];
      flag_z_q <= (RST_V == '0);
      upd_q    <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      upd_q  <= we_d;
      wrap_q <= wrap_d;
      if (we_d) begin
        flag_n_q <= wdata_d[WIDTH-1];
        flag_z_q <= (wdata_d == '0);
      end
    end
  end

  assign flag_n   = flag_n_q;
  assign flag_z   = flag_z_q;
  assign flag_upd = upd_q;
  assign wrap     = wrap_q;

endmodule

// File: tb/tb_index_register_file.sv
// Bench for index_register_file: scoreboard on the default build,
// directed checks on a 16-bit, 3-register build.
module tb_index_register_file;

  logic       fclk = 1'b0;
  always #5 fclk = ~fclk;

  // default build (8 bit, X/Y)
  logic       resb;
  logic       load, xfer, inc, dec;
  logic [0:0] wr_sel, xfer_src, rd_sel, addr_sel;
  logic [7:0] db_in, db_out, address_out;
  logic       flag_n, flag_z, flag_upd, wrap;

  index_register_file u_dut (
    .fclk(fclk), .resb(resb), .load(load), .wr_sel(wr_sel),
    .db_in(db_in), .xfer(xfer), .xfer_src(xfer_src), .inc(inc),
    .dec(dec), .rd_sel(rd_sel), .addr_sel(addr_sel), .db_out(db_out),
    .address_out(address_out), .flag_n(flag_n), .flag_z(flag_z),
    .flag_upd(flag_upd), .wrap(wrap)
  );

  // wide build
  logic        resb_b;
  logic        load_b, xfer_b, inc_b, dec_b;
  logic [1:0]  wr_sel_b, xfer_src_b, rd_sel_b, addr_sel_b;
  logic [15:0] db_in_b, db_out_b, address_out_b;
  logic        flag_n_b, flag_z_b, flag_upd_b, wrap_b;

  index_register_file #(
    .WIDTH(16), .NUM_REGS(3), .RESET_VALUE(32'h00FF)
  ) u_dut_b (
    .fclk(fclk), .resb(resb_b), .load(load_b), .wr_sel(wr_sel_b),
    .db_in(db_in_b), .xfer(xfer_b), .xfer_src(xfer_src_b), .inc(inc_b),
    .dec(dec_b), .rd_sel(rd_sel_b), .addr_sel(addr_sel_b),
    .db_out(db_out_b), .address_out(address_out_b), .flag_n(flag_n_b),
    .flag_z(flag_z_b), .flag_upd(flag_upd_b), .wrap(wrap_b)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  typedef struct {
    string      tag;
    logic [7:0] db;
    logic [7:0] ad;
    logic       n;
    logic       z;
    logic       upd;
    logic       wr;
  } exp_t;

  exp_t sb[$];

  // reference state
  logic [7:0] m_r [2];
  logic       m_n, m_z;

  task automatic drive_a(logic ld, logic xf, logic in, logic de,
                         logic ws, logic xs, logic [7:0] d,
                         logic rs, logic as);
    load = ld; xfer = xf; inc = in; dec = de;
    wr_sel = ws; xfer_src = xs; db_in = d;
    rd_sel = rs; addr_sel = as;
  endtask

  task automatic compare_head();
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_empty", 1, 0);
      return;
    end
    e = sb.pop_front();
    check({e.tag, ".db"},   db_out,      e.db);
    check({e.tag, ".ad"},   address_out, e.ad);
    check({e.tag, ".n"},    flag_n,      e.n);
    check({e.tag, ".z"},    flag_z,      e.z);
    check({e.tag, ".upd"},  flag_upd,    e.upd);
    check({e.tag, ".wrap"}, wrap,        e.wr);
  endtask

  task automatic step(string tag, logic ld, logic xf, logic in,
                      logic de, logic ws, logic xs, logic [7:0] d,
                      logic rs, logic as);
    logic       w;
    logic       wp;
    logic [7:0] v;
    exp_t       e;
    @(negedge fclk);
    drive_a(ld, xf, in, de, ws, xs, d, rs, as);
    #1;
    check({tag, ".pre_db"}, db_out,      m_r[rs]);
    check({tag, ".pre_ad"}, address_out, m_r[as]);
    w  = 1'b0;
    wp = 1'b0;
    v  = 8'h00;
    if (ld) begin
      w = 1'b1; v = d;
    end else if (xf) begin
      w = 1'b1; v = m_r[xs];
    end else if (in && !de) begin
      w = 1'b1; v = m_r[ws] + 8'd1; wp = (m_r[ws] == 8'hFF);
    end else if (de && !in) begin
      w = 1'b1; v = m_r[ws] - 8'd1; wp = (m_r[ws] == 8'h00);
    end
    if (w) begin
      m_r[ws] = v;
      m_n = v[7];
      m_z = (v == 8'h00);
    end
    e.tag = tag;
    e.db  = m_r[rs];
    e.ad  = m_r[as];
    e.n   = m_n;
    e.z   = m_z;
    e.upd = w;
    e.wr  = wp;
    sb.push_back(e);
    @(posedge fclk);
    #1;
    compare_head();
  endtask

  task automatic reset_a(int cycles, logic busy);
    @(negedge fclk);
    resb = 1'b0;
    drive_a(busy, 1'b0, busy, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1);
    repeat (cycles) @(posedge fclk);
    @(negedge fclk);
    resb = 1'b1;
    drive_a(0, 0, 0, 0, 0, 0, 8'h00, 0, 1);
    m_r[0] = 8'h00;
    m_r[1] = 8'h00;
    m_n = 1'b0;
    m_z = 1'b1;
    #1;
    check("rst.db_x", db_out,      8'h00);
    check("rst.ad_y", address_out, 8'h00);
    rd_sel = 1'b1; addr_sel = 1'b0;
    #1;
    check("rst.db_y", db_out,      8'h00);
    check("rst.ad_x", address_out, 8'h00);
    check("rst.z",    flag_z,   1'b1);
    check("rst.n",    flag_n,   1'b0);
    check("rst.upd",  flag_upd, 1'b0);
    check("rst.wrap", wrap,     1'b0);
  endtask

  task automatic drive_b(logic ld, logic in, logic [1:0] ws,
                         logic [15:0] d, logic [1:0] rs,
                         logic [1:0] as);
    load_b = ld; xfer_b = 1'b0; inc_b = in; dec_b = 1'b0;
    wr_sel_b = ws; xfer_src_b = 2'd0; db_in_b = d;
    rd_sel_b = rs; addr_sel_b = as;
  endtask

  task automatic check_b_regs(string tag, logic [15:0] x,
                              logic [15:0] y, logic [15:0] z);
    logic [15:0] exp [3];
    exp[0] = x; exp[1] = y; exp[2] = z;
    for (int i = 0; i < 3; i++) begin
      rd_sel_b = 2'(i);
      addr_sel_b = 2'(i);
      #1;
      check($sformatf("%s.db%0d", tag, i), db_out_b,      exp[i]);
      check($sformatf("%s.ad%0d", tag, i), address_out_b, exp[i]);
    end
  endtask

  initial begin
    resb = 1'b0;
    drive_a(0, 0, 0, 0, 0, 0, 8'h00, 0, 0);
    resb_b = 1'b0;
    drive_b(0, 0, 2'd0, 16'h0, 2'd0, 2'd0);

    reset_a(2, 1'b0);

    step("ldY80", 1, 0, 0, 0, 1, 0, 8'h80, 1, 0);
    step("hold1", 0, 0, 0, 0, 0, 0, 8'h00, 1, 0);

    step("ldXFF", 1, 0, 0, 0, 0, 0, 8'hFF, 0, 1);
    step("incX",  0, 0, 1, 0, 0, 0, 8'h00, 0, 1);
    step("decX",  0, 0, 0, 1, 0, 0, 8'h00, 0, 1);
    step("hold2", 0, 0, 0, 0, 0, 0, 8'h00, 0, 1);

    step("ldinc", 1, 0, 1, 0, 0, 0, 8'h10, 0, 1);
    step("incdec", 0, 0, 1, 1, 0, 0, 8'h00, 0, 1);

    step("ldX3C", 1, 0, 0, 0, 0, 0, 8'h3C, 1, 0);
    step("xferYX", 0, 1, 0, 0, 1, 0, 8'h00, 1, 0);
    step("xferXX", 0, 1, 0, 0, 0, 0, 8'h00, 0, 1);
    step("xfinc", 0, 1, 1, 0, 0, 1, 8'h00, 0, 1);
    step("ldY00", 1, 0, 0, 0, 1, 0, 8'h00, 1, 0);
    step("decY",  0, 0, 0, 1, 1, 0, 8'h00, 1, 0);

    for (int i = 0; i < 40; i++) begin
      step($sformatf("rnd%0d", i),
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 4) == 0),
           1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           8'($urandom), 1'($urandom), 1'($urandom));
    end

    reset_a(1, 1'b1);
    step("post_rst", 0, 0, 1, 0, 1, 0, 8'h00, 1, 0);

    // wide build: count up, then reset mid-increment
    @(negedge fclk);
    resb_b = 1'b1;
    drive_b(1, 0, 2'd1, 16'h1234, 2'd1, 2'd3);
    @(negedge fclk);
    drive_b(0, 1, 2'd1, 16'h0, 2'd1, 2'd3);
    @(negedge fclk);
    #1;
    check("b.inc_db", db_out_b, 16'h1235);
    resb_b = 1'b0;
    @(negedge fclk);
    drive_b(0, 0, 2'd0, 16'h0, 2'd0, 2'd0);
    #1;
    check("b.rst_z",   flag_z_b,   1'b0);
    check("b.rst_n",   flag_n_b,   1'b0);
    check("b.rst_upd", flag_upd_b, 1'b0);
    check_b_regs("b.rst", 16'h00FF, 16'h00FF, 16'h00FF);
    resb_b = 1'b1;
    drive_b(1, 0, 2'd3, 16'h1234, 2'd0, 2'd3);
    @(negedge fclk);
    drive_b(0, 1, 2'd3, 16'h0, 2'd0, 2'd3);
    #1;
    check("b.ws3_upd",  flag_upd_b,    1'b0);
    check("b.ad3",      address_out_b, 16'h0000);
    @(negedge fclk);
    #1;
    check("b.ws3_upd2", flag_upd_b, 1'b0);
    check("b.ws3_wrap", wrap_b,     1'b0);
    check_b_regs("b.ws3", 16'h00FF, 16'h00FF, 16'h00FF);
    drive_b(1, 0, 2'd2, 16'hFFFF, 2'd0, 2'd0);
    @(negedge fclk);
    drive_b(0, 1, 2'd2, 16'h0, 2'd2, 2'd2);
    #1;
    check("b.ld2_n",   flag_n_b,   1'b1);
    check("b.ld2_upd", flag_upd_b, 1'b1);
    check("b.ld2_db",  db_out_b,   16'hFFFF);
    @(negedge fclk);
    drive_b(0, 0, 2'd0, 16'h0, 2'd2, 2'd0);
    #1;
    check("b.inc2_wrap", wrap_b,   1'b1);
    check("b.inc2_z",    flag_z_b, 1'b1);
    check("b.inc2_db",   db_out_b, 16'h0000);

    check("sb_drained", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/index_register_file.md
INDEX_REGISTER_FILE -- requirements
Module: index_register_file

Interface
REQ-001 Parameter WIDTH, default 8, data width of every register and data port; legal range 4..32.
REQ-002 Parameter NUM_REGS, default 2, number of index registers (index 0 = X, index 1 = Y); legal range 2..8.
REQ-003 Parameter RESET_VALUE, default 0, value loaded into every register on reset.
REQ-004 Derived constant SEL_W = max(1, clog2(NUM_REGS)), width of all selector ports.
REQ-005 Clocking and reset: one clock; reset is synchronous and active-low.
REQ-006 fclk  input  1  system clock; all state updates on the rising edge.
REQ-007 resb  input  1  synchronous active-low reset.
REQ-008 load  input  1  write db_in into register wr_sel.
REQ-009 wr_sel  input  SEL_W  target register for load, xfer, inc and dec.
REQ-010 db_in  input  WIDTH  load data.
REQ-011 xfer  input  1  copy register xfer_src into register wr_sel.
REQ-012 xfer_src  input  SEL_W  source register for xfer.
REQ-013 inc  input  1  increment register wr_sel by 1 (modulo 2^WIDTH).
REQ-014 dec  input  1  decrement register wr_sel by 1 (modulo 2^WIDTH).
REQ-015 rd_sel  input  SEL_W  register driven onto db_out.
REQ-016 addr_sel  input  SEL_W  register driven onto address_out.
REQ-017 db_out  output  WIDTH  combinational read of register rd_sel.
REQ-018 address_out  output  WIDTH  combinational read of register addr_sel.
REQ-019 flag_n  output  1  registered MSB of the most recently written value.
REQ-020 flag_z  output  1  registered "most recently written value == 0".
REQ-021 flag_upd  output  1  one-cycle pulse: flag_n/flag_z were updated on the preceding edge.
REQ-022 wrap  output  1  one-cycle pulse: the preceding inc or dec wrapped.

Function
REQ-023 Exactly one register write per cycle; operation priority load > xfer > inc > dec.
REQ-024 load: reg[wr_sel] <= db_in on the edge; new value visible on db_out/address_out in the following cycle.
REQ-025 xfer: reg[wr_sel] <= reg[xfer_src], using the pre-edge source value; xfer with xfer_src == wr_sel rewrites the same value and still counts as a write.
REQ-026 inc alone: reg[wr_sel] <= reg[wr_sel] + 1, truncated to WIDTH bits.
REQ-027 dec alone: reg[wr_sel] <= reg[wr_sel] - 1, truncated to WIDTH bits.
REQ-028 inc and dec asserted together with no load/xfer: no operation, no register change, flag_upd and wrap stay 0.
REQ-029 wrap pulses for one cycle after inc from 2^WIDTH-1 to 0 or dec from 0 to 2^WIDTH-1; wrap is 0 after load or xfer.
REQ-030 On every executed write, flag_n <= written value[WIDTH-1], flag_z <= (written value == 0), and flag_upd pulses high for the next cycle; flags otherwise hold.
REQ-031 wr_sel or xfer_src >= NUM_REGS: operation ignored entirely (no write, no flag update, no wrap).
REQ-032 rd_sel or addr_sel >= NUM_REGS: the corresponding output reads all zeros.
REQ-033 Read ports never bypass: a read during a write cycle returns the pre-edge value.
REQ-034 Unselected registers hold their value every cycle.

Reset
REQ-035 With resb low at an edge: all registers <= RESET_VALUE, flag_n <= RESET_VALUE[WIDTH-1], flag_z <= (RESET_VALUE == 0), flag_upd <= 0, wrap <= 0.
REQ-036 Reset overrides every operation in the same cycle, including a write in progress.
REQ-037 The first operation is accepted on the first edge with resb high.

Verification
REQ-038 Reset then read: resb low for 2 cycles, release -> db_out = address_out = 0x00 for all selectors, flag_z = 1, flag_upd = 0.
REQ-039 Load/flags: load 0x80 into Y (wr_sel = 1) -> next cycle db_out(rd_sel = 1) = 0x80, flag_n = 1, flag_z = 0, flag_upd pulse of exactly 1 cycle.
REQ-040 Wrap: load X = 0xFF, then inc X -> X = 0x00, wrap = 1 for one cycle, flag_z = 1; then dec X -> X = 0xFF, wrap = 1, flag_n = 1.
REQ-041 Priority and simultaneous events: load = inc = 1, db_in = 0x10 -> reg = 0x10, wrap = 0; inc = dec = 1 only -> no change, flag_upd = 0.
REQ-042 Transfer: X = 0x3C, xfer with wr_sel = Y, xfer_src = X -> Y = 0x3C, X unchanged; same-cycle rd_sel = Y still shows the old Y.
REQ-043 Parameter sweep: WIDTH = 16, NUM_REGS = 3, RESET_VALUE = 0x00FF; reset mid-increment -> all registers = 0x00FF, flag_z = 0; wr_sel = 3 is ignored and address_out(addr_sel = 3) = 0x0000.
